// File: rtl/pc_sequencer_if.sv
// Interface between the control unit / instruction memory and the PC sequencer.
// The master side drives the redirect decisions and the imem acknowledge.
// The slave side (the sequencer) drives the fetch port, the PC and the status flags.
interface pc_sequencer_if;
    logic        stall;
    logic        halt;
    logic        trap;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_ack;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        halted;
    logic        misalign;
    logic        fetch_err;
    logic [31:0] instret;

    modport master (
        output stall, halt, trap, jmp, jmp_target, br_taken, br_target, imem_ack,
        input  imem_req, imem_addr, pc, pc_plus4, instr_valid, halted, misalign,
               fetch_err, instret
    );

    modport slave (
        input  stall, halt, trap, jmp, jmp_target, br_taken, br_target, imem_ack,
        output imem_req, imem_addr, pc, pc_plus4, instr_valid, halted, misalign,
               fetch_err, instret
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch / next-PC controller. Owns the PC, runs the IDLE -> FETCH -> EXEC loop,
// arbitrates halt > trap > jmp > branch > sequential, redirects misaligned
// targets to the trap vector, flags fetch timeouts and counts retired instructions.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0010,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic          clk,
    input  logic          rst,
    pc_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    // Last counter value before the timeout fires; the counter starts at 0 in
    // the first FETCH cycle, so TIMEOUT unacknowledged cycles end the fetch.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [31:0] pc_q, pc_nxt;
    logic [31:0] instret_q, instret_nxt;
    logic [7:0]  tmo_q, tmo_nxt;
    logic        ferr_q, ferr_nxt;
    logic        mis_q, mis_nxt;
    logic [31:0] pc_plus4;

    function automatic logic is_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

    assign pc_plus4 = pc_q + 32'd4;

    // Next-state, next-PC, timeout and retire-count decisions
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc_q;
        instret_nxt = instret_q;
        tmo_nxt     = tmo_q;
        ferr_nxt    = ferr_q;
        mis_nxt     = 1'b0;
        unique case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                if (bus.imem_ack) begin
                    state_nxt = EXEC;
                    tmo_nxt   = 8'd0;
                end else if (tmo_q == TMO_LAST) begin
                    state_nxt = HALT;
                    ferr_nxt  = 1'b1;
                    tmo_nxt   = 8'd0;
                end else begin
                    tmo_nxt = tmo_q + 8'd1;
                end
            end
            EXEC: begin
                // A stalled instruction ignores every redirect request.
                if (!bus.stall) begin
                    instret_nxt = instret_q + 32'd1;
                    if (bus.halt) begin
                        state_nxt = HALT;
                    end else begin
                        state_nxt = FETCH;
                        if (bus.trap) begin
                            pc_nxt = TRAP_VEC;
                        end else if (bus.jmp) begin
                            pc_nxt  = is_aligned(bus.jmp_target) ? bus.jmp_target : TRAP_VEC;
                            mis_nxt = !is_aligned(bus.jmp_target);
                        end else if (bus.br_taken) begin
                            pc_nxt  = is_aligned(bus.br_target) ? bus.br_target : TRAP_VEC;
                            mis_nxt = !is_aligned(bus.br_target);
                        end else begin
                            pc_nxt = pc_plus4;
                        end
                    end
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, PC, counters and sticky/pulse flags; reset is asynchronous
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pc_q      <= RESET_PC;
            instret_q <= 32'd0;
            tmo_q     <= 8'd0;
            ferr_q    <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc_q      <= pc_nxt;
            instret_q <= instret_nxt;
            tmo_q     <= tmo_nxt;
            ferr_q    <= ferr_nxt;
            mis_q     <= mis_nxt;
        end
    end

    assign bus.imem_req    = (state == FETCH);
    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.instr_valid = (state == EXEC);
    assign bus.halted      = (state == HALT);
    assign bus.misalign    = mis_q;
    assign bus.fetch_err   = ferr_q;
    assign bus.instret     = instret_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: reset, redirect-priority vector table,
// hand-written multi-cycle sequences, and a randomized run against a
// transaction-level reference model.
module tb_pc_sequencer;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0010;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    pc_sequencer_if bus();

    pc_sequencer #(
        .RESET_PC(32'h0000_0000),
        .TRAP_VEC(TRAP_VEC),
        .TIMEOUT (15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic        stall, halt, trap, jmp;
        logic [31:0] jt;
        logic        br;
        logic [31:0] bt;
        logic        exp_req, exp_valid, exp_mis, exp_halted;
        logic [31:0] exp_addr, exp_instret;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(input string n, input logic s, input logic h, input logic t,
                                input logic j, input logic [31:0] jt, input logic b,
                                input logic [31:0] bt, input logic rq, input logic v,
                                input logic m, input logic hl, input logic [31:0] a,
                                input logic [31:0] ir);
        vec_t r;
        r.name = n; r.stall = s; r.halt = h; r.trap = t; r.jmp = j; r.jt = jt;
        r.br = b; r.bt = bt; r.exp_req = rq; r.exp_valid = v; r.exp_mis = m;
        r.exp_halted = hl; r.exp_addr = a; r.exp_instret = ir;
        return r;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.stall = 0; bus.halt = 0; bus.trap = 0; bus.jmp = 0; bus.jmp_target = 0;
        bus.br_taken = 0; bus.br_target = 0; bus.imem_ack = 0;
    endtask

    // Leaves the DUT just out of reset, in its IDLE cycle.
    task automatic do_reset();
        clear_in();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    // Brings the DUT to EXEC at address t (aligned) with instret = 1.
    task automatic goto_exec(input logic [31:0] t);
        do_reset();
        bus.imem_ack = 1;
        step();              // FETCH at 0
        step();              // EXEC at 0
        bus.jmp = 1; bus.jmp_target = t;
        step();              // FETCH at t
        bus.jmp = 0;
        step();              // EXEC at t
        bus.imem_ack = 0;
    endtask

    function automatic logic [31:0] rnd_target();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(4) != 0) t[1:0] = 2'b00;
        return t;
    endfunction

    // Reference next-PC rule for a retiring, non-halting instruction.
    function automatic void ref_next(input logic [31:0] cur, input logic trap, input logic jmp,
                                     input logic [31:0] jt, input logic br, input logic [31:0] bt,
                                     output logic [31:0] nxt, output logic mis);
        mis = 0;
        if (trap)      nxt = TRAP_VEC;
        else if (jmp)  nxt = jt;
        else if (br)   nxt = bt;
        else           nxt = cur + 32'd4;
        if (!trap && (jmp || br) && (nxt % 4 != 0)) begin
            mis = 1;
            nxt = TRAP_VEC;
        end
    endfunction

    // Random-run model state: outstanding fetch addresses and retire count.
    logic [31:0] q_addr[$];
    logic [31:0] m_pc;
    int          m_ret;
    bit          m_fetch_pending, m_in_exec, exp_mis, exp_halt;
    int          wait_n;
    int          n_halts;

    task automatic rand_restart();
        do_reset();
        step();              // first FETCH cycle
        q_addr.delete();
        q_addr.push_back(32'h0);
        m_pc = 0; m_ret = 0; m_fetch_pending = 1; m_in_exec = 0;
        exp_mis = 0; exp_halt = 0; wait_n = 0;
    endtask

    initial begin
        int          n;
        logic [31:0] nxt;
        logic        mis;

        // Reset state
        rst = 1'b0;
        clear_in();
        step();
        step();
        chk1("rst_req", bus.imem_req, 0);
        chk1("rst_valid", bus.instr_valid, 0);
        chk1("rst_halted", bus.halted, 0);
        chk1("rst_misalign", bus.misalign, 0);
        chk1("rst_fetch_err", bus.fetch_err, 0);
        chk32("rst_pc", bus.pc, 32'h0);
        chk32("rst_instret", bus.instret, 32'h0);

        // Sequential fetch loop with ack tied high
        rst = 1'b1;
        bus.imem_ack = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk1("seq_req", bus.imem_req, 1);
            chk32("seq_addr", bus.imem_addr, 32'(4 * i));
            chk32("seq_instret_fetch", bus.instret, 32'(i));
            step();
            chk1("seq_valid", bus.instr_valid, 1);
            chk1("seq_req_exec", bus.imem_req, 0);
        end
        step();
        chk32("seq_instret3", bus.instret, 32'd3);
        chk32("seq_addr3", bus.imem_addr, 32'hC);

        // Redirect priority table, each applied from EXEC at 0x20
        vecs[0] = mk("plain",        0,0,0,0,32'h0,  0,32'h0,  1,0,0,0,32'h24, 2);
        vecs[1] = mk("trap_wins",    0,0,1,1,32'h100,1,32'h200,1,0,0,0,32'h10, 2);
        vecs[2] = mk("jmp_over_br",  0,0,0,1,32'h100,1,32'h200,1,0,0,0,32'h100,2);
        vecs[3] = mk("br_taken",     0,0,0,0,32'h0,  1,32'h200,1,0,0,0,32'h200,2);
        vecs[4] = mk("br_misalign",  0,0,0,0,32'h0,  1,32'h42, 1,0,1,0,32'h10, 2);
        vecs[5] = mk("jmp_misalign", 0,0,0,1,32'h101,1,32'h200,1,0,1,0,32'h10, 2);
        vecs[6] = mk("br_mis_drop",  0,0,0,1,32'h100,1,32'h43, 1,0,0,0,32'h100,2);
        vecs[7] = mk("trap_mis_jmp", 0,0,1,1,32'h102,0,32'h0,  1,0,0,0,32'h10, 2);
        vecs[8] = mk("halt_wins",    0,1,1,1,32'h100,0,32'h0,  0,0,0,1,32'h20, 2);
        vecs[9] = mk("stall_hold",   1,0,1,1,32'h100,1,32'h200,0,1,0,0,32'h20, 1);
        foreach (vecs[k]) begin
            goto_exec(32'h20);
            bus.stall = vecs[k].stall; bus.halt = vecs[k].halt; bus.trap = vecs[k].trap;
            bus.jmp = vecs[k].jmp; bus.jmp_target = vecs[k].jt;
            bus.br_taken = vecs[k].br; bus.br_target = vecs[k].bt;
            step();
            chk1({vecs[k].name, "_req"}, bus.imem_req, vecs[k].exp_req);
            chk1({vecs[k].name, "_valid"}, bus.instr_valid, vecs[k].exp_valid);
            chk1({vecs[k].name, "_mis"}, bus.misalign, vecs[k].exp_mis);
            chk1({vecs[k].name, "_halted"}, bus.halted, vecs[k].exp_halted);
            chk32({vecs[k].name, "_addr"}, bus.imem_addr, vecs[k].exp_addr);
            chk32({vecs[k].name, "_instret"}, bus.instret, vecs[k].exp_instret);
            clear_in();
            step();
            chk1({vecs[k].name, "_mis_pulse_end"}, bus.misalign, 0);
        end

        // Stall with a jump request held, then released without redirect
        goto_exec(32'h20);
        bus.stall = 1; bus.jmp = 1; bus.jmp_target = 32'h100;
        for (int i = 0; i < 3; i++) begin
            step();
            chk1("stall_valid", bus.instr_valid, 1);
            chk32("stall_pc", bus.pc, 32'h20);
            chk32("stall_instret", bus.instret, 32'd1);
        end
        bus.stall = 0; bus.jmp = 0;
        step();
        chk1("unstall_req", bus.imem_req, 1);
        chk32("unstall_addr", bus.imem_addr, 32'h24);
        chk32("unstall_instret", bus.instret, 32'd2);

        // Fetch timeout: no ack ever arrives
        do_reset();
        step();
        n = 0;
        while (bus.imem_req && n < 100) begin
            n++;
            step();
        end
        chk32("tmo_fetch_cycles", 32'(n), 32'd15);
        chk1("tmo_halted", bus.halted, 1);
        chk1("tmo_fetch_err", bus.fetch_err, 1);
        chk1("tmo_req", bus.imem_req, 0);
        bus.imem_ack = 1;
        repeat (3) step();
        chk1("tmo_halted_sticky", bus.halted, 1);
        chk1("tmo_err_sticky", bus.fetch_err, 1);
        #2;
        rst = 1'b0;
        #1;
        chk1("tmo_rst_halted", bus.halted, 0);
        chk1("tmo_rst_err", bus.fetch_err, 0);
        chk32("tmo_rst_pc", bus.pc, 32'h0);

        // Asynchronous reset drops imem_req mid-FETCH without a clock edge
        do_reset();
        step();
        chk1("async_req_before", bus.imem_req, 1);
        #2;
        rst = 1'b0;
        #1;
        chk1("async_req_drop", bus.imem_req, 0);

        // PC wrap at the top of the address space, then halt
        goto_exec(32'hFFFF_FFFC);
        chk32("wrap_pc_plus4", bus.pc_plus4, 32'h0);
        step();
        chk1("wrap_req", bus.imem_req, 1);
        chk32("wrap_addr", bus.imem_addr, 32'h0);
        bus.imem_ack = 1;
        step();
        chk1("wrap_exec", bus.instr_valid, 1);
        bus.halt = 1;
        step();
        bus.halt = 0;
        chk1("halt_halted", bus.halted, 1);
        n = 0;
        repeat (5) begin
            step();
            if (bus.imem_req) n++;
        end
        chk32("halt_no_req", 32'(n), 32'd0);
        chk1("halt_valid", bus.instr_valid, 0);

        // Randomized run against the transaction-level model
        n_halts = 0;
        rand_restart();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk1("rnd_req", bus.imem_req, m_fetch_pending && !exp_halt);
            chk1("rnd_valid", bus.instr_valid, m_in_exec);
            chk1("rnd_halted", bus.halted, exp_halt);
            chk1("rnd_misalign", bus.misalign, exp_mis);
            chk32("rnd_instret", bus.instret, 32'(m_ret));
            if (exp_halt || bus.halted) begin
                n_halts++;
                rand_restart();
                continue;
            end
            bus.stall      = ($urandom_range(3) == 0);
            bus.halt       = ($urandom_range(63) == 0);
            bus.trap       = ($urandom_range(7) == 0);
            bus.jmp        = ($urandom_range(3) == 0);
            bus.br_taken   = ($urandom_range(2) == 0);
            bus.jmp_target = rnd_target();
            bus.br_target  = rnd_target();
            bus.imem_ack   = (wait_n >= 8) ? 1'b1 : ($urandom_range(3) != 0);
            if (m_fetch_pending && !bus.imem_ack) wait_n++;
            else wait_n = 0;
            exp_mis = 0;
            if (m_fetch_pending && bus.imem_ack) begin
                if (q_addr.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rnd_queue: fetch accepted with no expected address");
                end else begin
                    m_pc = q_addr.pop_front();
                    chk32("rnd_fetch_addr", bus.imem_addr, m_pc);
                end
                m_fetch_pending = 0;
                m_in_exec = 1;
            end else if (m_in_exec && !bus.stall) begin
                m_ret++;
                m_in_exec = 0;
                if (bus.halt) begin
                    exp_halt = 1;
                end else begin
                    ref_next(m_pc, bus.trap, bus.jmp, bus.jmp_target, bus.br_taken,
                             bus.br_target, nxt, mis);
                    q_addr.push_back(nxt);
                    exp_mis = mis;
                    m_fetch_pending = 1;
                end
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
